// File: rtl/tpu_systolic_array_if.sv
`default_nettype none
// ============================================================================
// Module      : tpu_systolic_array_if
// Description : Tile handshake between the TPU controller and the 4x4 array.
// Revision    : 1.0 - initial release
// ============================================================================
interface tpu_systolic_array_if #(
    parameter int DATA_BITS  = 32,
    parameter int DATAC_BITS = 128
);
    logic                  sa_rst_n;
    logic [DATA_BITS-1:0]  local_buffer_A0;
    logic [DATA_BITS-1:0]  local_buffer_A1;
    logic [DATA_BITS-1:0]  local_buffer_A2;
    logic [DATA_BITS-1:0]  local_buffer_A3;
    logic [DATA_BITS-1:0]  local_buffer_B0;
    logic [DATA_BITS-1:0]  local_buffer_B1;
    logic [DATA_BITS-1:0]  local_buffer_B2;
    logic [DATA_BITS-1:0]  local_buffer_B3;
    logic                  done;
    logic [DATAC_BITS-1:0] local_buffer_C0;
    logic [DATAC_BITS-1:0] local_buffer_C1;
    logic [DATAC_BITS-1:0] local_buffer_C2;
    logic [DATAC_BITS-1:0] local_buffer_C3;

    modport master (
        output sa_rst_n,
        output local_buffer_A0, local_buffer_A1, local_buffer_A2, local_buffer_A3,
        output local_buffer_B0, local_buffer_B1, local_buffer_B2, local_buffer_B3,
        input  done,
        input  local_buffer_C0, local_buffer_C1, local_buffer_C2, local_buffer_C3
    );

    modport slave (
        input  sa_rst_n,
        input  local_buffer_A0, local_buffer_A1, local_buffer_A2, local_buffer_A3,
        input  local_buffer_B0, local_buffer_B1, local_buffer_B2, local_buffer_B3,
        output done,
        output local_buffer_C0, local_buffer_C1, local_buffer_C2, local_buffer_C3
    );
endinterface
`default_nettype wire

// File: rtl/tpu_systolic_array.sv
`default_nettype none
// ============================================================================
// Module      : tpu_systolic_array
// Description : 4x4 output-stationary int8 systolic array, one K=4 tile.
// Revision    : 1.0 - initial release
// ============================================================================
module tpu_systolic_array (
    input  wire logic           clk,
    input  wire logic           rst_n,
    tpu_systolic_array_if.slave sa
);
    localparam logic [3:0] c_LAST = 4'd10;

    logic [3:0]        r_cnt;
    logic              r_done;
    logic [7:0]        r_h   [4][4];
    logic [7:0]        r_v   [4][4];
    logic [31:0]       r_acc [4][4];

    logic [31:0]       w_a    [4];
    logic [31:0]       w_b    [4];
    logic [7:0]        w_a_in [4];
    logic [7:0]        w_b_in [4];
    logic signed [15:0] w_prod [4][4];

    assign w_a[0] = sa.local_buffer_A0;
    assign w_a[1] = sa.local_buffer_A1;
    assign w_a[2] = sa.local_buffer_A2;
    assign w_a[3] = sa.local_buffer_A3;
    assign w_b[0] = sa.local_buffer_B0;
    assign w_b[1] = sa.local_buffer_B1;
    assign w_b[2] = sa.local_buffer_B2;
    assign w_b[3] = sa.local_buffer_B3;

    // Row m / column n is skewed by m / n cycles so operands meet at PE(m,n).
    always_comb begin
        for (int m = 0; m < 4; m++) begin
            w_a_in[m] = 8'd0;
            w_b_in[m] = 8'd0;
            for (int k = 0; k < 4; k++) begin
                if (r_cnt == 4'(k + m)) begin
                    w_a_in[m] = w_a[k][31-8*m -: 8];
                    w_b_in[m] = w_b[k][31-8*m -: 8];
                end
            end
        end
    end

    always_comb begin
        for (int m = 0; m < 4; m++) begin
            for (int n = 0; n < 4; n++) begin
                w_prod[m][n] = $signed(r_h[m][n]) * $signed(r_v[m][n]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !sa.sa_rst_n) begin
            r_cnt  <= 4'd0;
            r_done <= 1'b0;
            for (int m = 0; m < 4; m++) begin
                for (int n = 0; n < 4; n++) begin
                    r_h[m][n]   <= 8'd0;
                    r_v[m][n]   <= 8'd0;
                    r_acc[m][n] <= 32'd0;
                end
            end
        end else if (r_cnt <= c_LAST) begin
            for (int m = 0; m < 4; m++) begin
                r_h[m][0] <= w_a_in[m];
                r_v[0][m] <= w_b_in[m];
                for (int n = 1; n < 4; n++) begin
                    r_h[m][n] <= r_h[m][n-1];
                    r_v[n][m] <= r_v[n-1][m];
                end
                for (int n = 0; n < 4; n++) begin
                    r_acc[m][n] <= r_acc[m][n] + {{16{w_prod[m][n][15]}}, w_prod[m][n]};
                end
            end
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt == c_LAST) begin
                r_done <= 1'b1;
            end
        end
    end

    assign sa.done            = r_done;
    assign sa.local_buffer_C0 = {r_acc[0][0], r_acc[0][1], r_acc[0][2], r_acc[0][3]};
    assign sa.local_buffer_C1 = {r_acc[1][0], r_acc[1][1], r_acc[1][2], r_acc[1][3]};
    assign sa.local_buffer_C2 = {r_acc[2][0], r_acc[2][1], r_acc[2][2], r_acc[2][3]};
    assign sa.local_buffer_C3 = {r_acc[3][0], r_acc[3][1], r_acc[3][2], r_acc[3][3]};
endmodule
`default_nettype wire

// File: tb/tb_tpu_systolic_array.sv
`default_nettype none
// ============================================================================
// Module      : tb_tpu_systolic_array
// Description : Self-checking bench for tpu_systolic_array against a matrix model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tpu_systolic_array;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [31:0]  tile_a [4];
    logic [31:0]  tile_b [4];

    tpu_systolic_array_if #(.DATA_BITS(32), .DATAC_BITS(128)) sa_if ();

    tpu_systolic_array dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sa    (sa_if.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // C = A^T * B over K=4 with signed int8 lanes, plain integer arithmetic.
    function automatic logic [127:0] model_row(input int m);
        logic [127:0] row;
        int           s;
        row = '0;
        for (int n = 0; n < 4; n++) begin
            s = 0;
            for (int k = 0; k < 4; k++) begin
                s += int'($signed(tile_a[k][31-8*m -: 8])) * int'($signed(tile_b[k][31-8*n -: 8]));
            end
            row[127-32*n -: 32] = s;
        end
        return row;
    endfunction

    function automatic logic [127:0] dut_row(input int m);
        case (m)
            0:       return sa_if.local_buffer_C0;
            1:       return sa_if.local_buffer_C1;
            2:       return sa_if.local_buffer_C2;
            default: return sa_if.local_buffer_C3;
        endcase
    endfunction

    task automatic drive_tile();
        sa_if.local_buffer_A0 = tile_a[0];
        sa_if.local_buffer_A1 = tile_a[1];
        sa_if.local_buffer_A2 = tile_a[2];
        sa_if.local_buffer_A3 = tile_a[3];
        sa_if.local_buffer_B0 = tile_b[0];
        sa_if.local_buffer_B1 = tile_b[1];
        sa_if.local_buffer_B2 = tile_b[2];
        sa_if.local_buffer_B3 = tile_b[3];
    endtask

    task automatic check_rows(input string tag);
        for (int m = 0; m < 4; m++) check($sformatf("%s_C%0d", tag, m), dut_row(m), model_row(m));
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_done"}, {127'd0, sa_if.done}, 128'd0);
        for (int m = 0; m < 4; m++) check($sformatf("%s_C%0d", tag, m), dut_row(m), 128'd0);
    endtask

    // Called at a negedge with the block cleared; the next posedge is compute edge 1.
    task automatic run_tile(input string tag);
        drive_tile();
        sa_if.sa_rst_n = 1'b1;
        for (int e = 1; e <= 11; e++) begin
            @(posedge clk); #1;
            if (e == 10) check({tag, "_done_e10"}, {127'd0, sa_if.done}, 128'd0);
        end
        check({tag, "_done_e11"}, {127'd0, sa_if.done}, 128'd1);
        check_rows(tag);
        @(negedge clk);
    endtask

    task automatic clear_one();
        sa_if.sa_rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
    endtask

    task automatic load_identity();
        tile_a[0] = 32'h01000000; tile_a[1] = 32'h00010000;
        tile_a[2] = 32'h00000100; tile_a[3] = 32'h00000001;
        tile_b[0] = 32'h01020304; tile_b[1] = 32'h05060708;
        tile_b[2] = 32'h090A0B0C; tile_b[3] = 32'h0D0E0F10;
    endtask

    initial begin
        rst_n = 1'b0;
        sa_if.sa_rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin tile_a[k] = '0; tile_b[k] = '0; end
        drive_tile();
        repeat (3) @(posedge clk);
        #1 check_cleared("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Identity A with ramp B
        load_identity();
        run_tile("ident");
        check("ident_C0_const", sa_if.local_buffer_C0, 128'h00000001_00000002_00000003_00000004);
        check("ident_C3_const", sa_if.local_buffer_C3, 128'h0000000D_0000000E_0000000F_00000010);

        // Hold for 20 cycles
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check($sformatf("hold%0d_done", i), {127'd0, sa_if.done}, 128'd1);
            check_rows($sformatf("hold%0d", i));
        end
        @(negedge clk);

        // Drop while done
        sa_if.sa_rst_n = 1'b0;
        @(posedge clk); #1;
        check_cleared("drop_done");
        @(negedge clk);

        // All-zero tile after reuse
        for (int k = 0; k < 4; k++) begin tile_a[k] = '0; tile_b[k] = '0; end
        run_tile("zero");
        clear_one();

        // Signed extremes
        for (int k = 0; k < 4; k++) begin tile_a[k] = 32'h80808080; tile_b[k] = 32'h80808080; end
        run_tile("ext");
        check("ext_C2_const", sa_if.local_buffer_C2, {4{32'h00010000}});
        clear_one();

        // Mixed sign
        for (int k = 0; k < 4; k++) begin tile_a[k] = 32'hFFFFFFFF; tile_b[k] = 32'h01010101; end
        run_tile("mix");
        check("mix_C1_const", sa_if.local_buffer_C1, {4{32'hFFFFFFFC}});
        clear_one();

        // Abort at cnt=5, then restart
        load_identity();
        drive_tile();
        sa_if.sa_rst_n = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        sa_if.sa_rst_n = 1'b0;
        @(posedge clk); #1;
        check_cleared("abort");
        @(negedge clk);
        run_tile("restart");

        // Reset precedence while done
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_cleared("rstp");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_cleared($sformatf("rstp_hold%0d", i));
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_tile("post_rst");
        clear_one();

        // Randomized tiles
        for (int t = 0; t < 20; t++) begin
            for (int k = 0; k < 4; k++) begin
                tile_a[k] = $urandom;
                tile_b[k] = $urandom;
            end
            run_tile($sformatf("rnd%0d", t));
            clear_one();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/tpu_systolic_array.md
# tpu_systolic_array

4x4 output-stationary systolic array that answers the TPU controller's tile handshake. The controller loads four A words and four B words into its local buffers, then raises sa_rst_n. This block then computes one 4x4 int8 tile product over K=4, raises done, and holds four packed 128-bit result rows. The controller accumulates those rows across K tiles and writes them to the C buffer.

## Interface
- DATA_BITS, 32, width of one A/B word: four int8 lanes. Fixed at 32.
- DATAC_BITS, 128, width of one C row: four 32-bit lanes. Fixed at 128.
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, synchronous, active-low; overrides all other inputs.
- sa_rst_n  in  1  tile enable/clear, active-low.
  - Low: array held cleared.
  - High: compute runs.
- local_buffer_A0..A3  in  DATA_BITS each  A word for k=0..3.
  - Row m operand is byte m; byte 0 is bits [31:24], byte 3 is bits [7:0].
- local_buffer_B0..B3  in  DATA_BITS each  B word for k=0..3.
  - Column n operand is byte n, same byte order as A.
- done  out  1  tile result valid; held while sa_rst_n stays high.
- local_buffer_C0..C3  out  DATAC_BITS each  result row m.
  - Lane n is bits [127-32n -: 32]; signed 32-bit.

## Operation
- Result definition: C[m][n] = sum over k=0..3 of sext(A_k.byte m) * sext(B_k.byte n).
  - Operands are signed int8; products are signed 16-bit, sign-extended to 32 bits.
  - Accumulation wraps modulo 2^32.
- State:
  - cnt: 4-bit cycle counter.
  - h[m][n], v[m][n]: 8-bit operand pipeline registers per PE.
  - acc[m][n]: 32-bit accumulator per PE.
  - done: 1-bit register.
- C outputs: local_buffer_Cm lane n = acc[m][n], driven directly from the registers.
- Clear (rst_n=0, or sa_rst_n=0): at the next posedge cnt, h, v, acc and done go to 0.
- Compute edge (rst_n=1, sa_rst_n=1, cnt<=10), with c = cnt:
  - Edge inputs: a_in[m] = A_(c-m).byte m if 0<=c-m<=3, else 0; b_in[n] = B_(c-n).byte n if 0<=c-n<=3, else 0.
  - Horizontal pipeline: h[m][0] <= a_in[m]; h[m][n] <= h[m][n-1].
  - Vertical pipeline: v[0][n] <= b_in[n]; v[m][n] <= v[m-1][n].
  - Accumulate: acc[m][n] <= acc[m][n] + h[m][n]*v[m][n], using pre-edge values.
  - Counter: cnt <= cnt+1.
  - done <= 1 when c==10.
- Hold (cnt==11, sa_rst_n=1): every register holds; cnt saturates at 11.
- States: CLEAR (cnt=0, array empty), RUN (cnt 1..10), DONE (cnt=11). Transitions:
  - CLEAR to RUN: first edge with sa_rst_n=1.
  - RUN to DONE: the edge at cnt=10.
  - Any state to CLEAR: an edge with sa_rst_n=0 or rst_n=0.
- A and B inputs are sampled every compute edge, not latched. The controller keeps them stable from the rise of sa_rst_n until done.

## Timing
- Reset values: done=0, C0..C3=0, cnt=0.
- Latency: done rises on the 11th posedge that samples sa_rst_n=1 (edge with cnt=10).
  - C reaches its final value on that same edge.
- While done=1 and sa_rst_n=1, C and done are stable indefinitely. The controller may sample C on any cycle in this window.
- sa_rst_n falls mid-compute (abort): next posedge clears everything, done=0, C=0.
  - A later rise starts a fresh 11-edge computation with no residue.
- sa_rst_n falls while done=1: done and C go to 0 on the next posedge.
- rst_n=0 together with sa_rst_n=1: rst_n wins; the block stays cleared.
- Minimum sa_rst_n low time: one posedge.
- Zero padding: the controller zeroes out-of-range A/B words; they contribute 0 and need no special handling here.

## Test plan
- Identity A with ramp B:
  - Stimulus: A0=0x01000000, A1=0x00010000, A2=0x00000100, A3=0x00000001; B0=0x01020304, B1=0x05060708, B2=0x090A0B0C, B3=0x0D0E0F10; raise sa_rst_n.
  - Response: done rises on edge 11. C0 = lanes {1,2,3,4}; C3 = lanes {13,14,15,16}.
- Signed extremes:
  - Stimulus: all A and B = 0x80808080.
  - Response: every lane of every C row = 0x00010000.
- Mixed sign:
  - Stimulus: all A = 0xFFFFFFFF, all B = 0x01010101.
  - Response: every lane = 0xFFFFFFFC.
- Abort and restart:
  - Stimulus: identity test, drop sa_rst_n at cnt=5 for one cycle, then re-raise.
  - Response: done=0 and C=0 after the drop. Identity result exact 11 edges after the re-raise.
- Reset precedence:
  - Stimulus: pull rst_n low while done=1 and sa_rst_n=1.
  - Response: next posedge gives done=0 and C=0; the block stays cleared while rst_n=0.
- Hold and reuse:
  - Stimulus: keep sa_rst_n high for 20 cycles after done, then clear, then run all-zero A/B.
  - Response: C is constant through the hold; the second tile gives all-zero C with done on edge 11.
